calc_acc16: RTL and testbench

- 16-bit accumulator calculator for a board-level top (5 push buttons, 16 switches, 16 LEDs).
- Each enabled clock, one ALU operation combines the accumulator with the switch value and writes the result back to the accumulator.
- The operation is selected by the left/centre/right buttons.
- LEDs continuously display the accumulator.
- Internally: op decoder + 32-bit ALU + 16-bit accumulator register.

---
 rtl/calc_acc16.sv | 73 +++++++
 tb/tb_calc_acc16.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/calc_acc16.sv
// calc_acc16: 16-bit accumulator calculator, acc <= acc op sw while btnd is high
//   clk            system clock, rising edge
//   btnu           asynchronous active-high reset, clears the accumulator
//   btnl/btnc/btnr op select {msb,mid,lsb}
//   btnd           accumulate enable
//   sw[15:0]       operand B, two's complement
//   led[15:0]      accumulator value
//   CALC_BTND_EDGE_EN: when defined, one operation per rising edge of btnd
module calc_acc16 (
  input  logic        clk,
  input  logic        btnu,
  input  logic        btnc,
  input  logic        btnl,
  input  logic        btnr,
  input  logic        btnd,
  input  logic [15:0] sw,
  output logic [15:0] led
);
  logic [15:0] r_acc;
  logic [2:0]  w_sel;
  logic [3:0]  w_code;
  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic [31:0] w_res;
  logic        w_zero;
  logic        w_en;
  logic        w_unused;
  assign w_sel = {btnl, btnc, btnr};
  assign w_op1 = {{16{r_acc[15]}}, r_acc};
  assign w_op2 = {{16{sw[15]}}, sw};
  always_comb begin
    case (w_sel)
      3'd0:    w_code = 4'b0010;
      3'd1:    w_code = 4'b0110;
      3'd2:    w_code = 4'b0000;
      3'd3:    w_code = 4'b0001;
      3'd4:    w_code = 4'b0101;
      3'd5:    w_code = 4'b0111;
      3'd6:    w_code = 4'b1001;
      default: w_code = 4'b1010;
    endcase
  end
  always_comb begin
    case (w_code)
      4'b0010: w_res = w_op1 + w_op2;
      4'b0110: w_res = w_op1 - w_op2;
      4'b0000: w_res = w_op1 & w_op2;
      4'b0001: w_res = w_op1 | w_op2;
      4'b0101: w_res = w_op1 ^ w_op2;
      4'b0111: w_res = {31'd0, $signed(w_op1) < $signed(w_op2)};
      4'b1000: w_res = w_op1 >> w_op2[4:0];
      4'b1001: w_res = w_op1 << w_op2[4:0];
      4'b1010: w_res = $unsigned($signed(w_op1) >>> w_op2[4:0]);
      default: w_res = 32'd0;
    endcase
  end
  assign w_zero   = (w_res == 32'd0);
  // zero flag and upper result half are architectural but not needed at the top
  assign w_unused = ^{w_zero, w_res[31:16]};
`ifdef CALC_BTND_EDGE_EN
  logic r_btnd;
  always_ff @(posedge clk or posedge btnu)
    if (btnu) r_btnd <= 1'b0;
    else      r_btnd <= btnd;
  assign w_en = btnd & ~r_btnd;
`else
  assign w_en = btnd;
`endif
  always_ff @(posedge clk or posedge btnu)
    if (btnu)      r_acc <= 16'h0000;
    else if (w_en) r_acc <= w_res[15:0];
  assign led = r_acc;
endmodule

// File: tb/tb_calc_acc16.sv
// tb_calc_acc16: scoreboard bench for calc_acc16
module tb_calc_acc16;
  logic        clk = 1'b0;
  logic        btnu = 1'b1;
  logic        btnc = 1'b0;
  logic        btnl = 1'b0;
  logic        btnr = 1'b0;
  logic        btnd = 1'b0;
  logic [15:0] sw = 16'h0000;
  logic [15:0] led;
  logic [15:0] q[$];
  logic [15:0] m_acc = 16'h0000;
  int errs = 0;
  int checks = 0;
  calc_acc16 dut (
    .clk(clk), .btnu(btnu), .btnc(btnc), .btnl(btnl),
    .btnr(btnr), .btnd(btnd), .sw(sw), .led(led)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  function automatic logic [15:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int sh;
    logic signed [15:0] s;
    logic [15:0] r;
    sh = int'(b[4:0]);
    s = a;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      3'd6: r = (sh >= 16) ? 16'd0 : a << sh;
      default: r = (sh >= 16) ? {16{a[15]}} : s >>> sh;
    endcase
    return r;
  endfunction
  task automatic pop_chk(input string tag);
    logic [15:0] e;
    e = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
    chk(tag, led, e);
  endtask
  task automatic step(input logic [2:0] op, input logic [15:0] b, input logic [15:0] exp, input string tag);
    @(negedge clk);
    {btnl, btnc, btnr} = op;
    sw = b;
    btnd = 1'b1;
    m_acc = exp;
    q.push_back(exp);
    @(posedge clk);
    #1 pop_chk(tag);
    @(negedge clk);
    btnd = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    btnu = 1'b1;
    #1 chk("rst_async", led, 16'h0000);
    @(negedge clk);
    btnu = 1'b0;
    m_acc = 16'h0000;
    @(posedge clk);
    #1 chk("rst_hold", led, 16'h0000);
  endtask
  initial begin
    logic [2:0] op;
    logic [15:0] b;
    #1 chk("reset_init", led, 16'h0000);
    do_reset();
    step(3'b011, 16'h1234, 16'h1234, "seq_or");
    step(3'b010, 16'h0FF0, 16'h0230, "seq_and");
    step(3'b000, 16'h324F, 16'h347F, "seq_add");
    step(3'b001, 16'h2D31, 16'h074E, "seq_sub");
    step(3'b100, 16'hFFFF, 16'hF8B1, "seq_xor");
    step(3'b101, 16'h7346, 16'h0001, "seq_slt1");
    step(3'b110, 16'h0004, 16'h0010, "seq_lsl");
    step(3'b111, 16'h0004, 16'h0001, "seq_asr");
    step(3'b101, 16'hFFFF, 16'h0000, "seq_slt0");
    do_reset();
    step(3'b011, 16'h7FFF, 16'h7FFF, "ld_7fff");
    step(3'b000, 16'h0001, 16'h8000, "add_wrap");
    step(3'b111, 16'h0004, 16'hF800, "asr4");
    do_reset();
    step(3'b011, 16'h8000, 16'h8000, "ld_8000");
    step(3'b111, 16'h0014, 16'hFFFF, "asr20");
    do_reset();
    step(3'b011, 16'h0001, 16'h0001, "ld_0001");
    step(3'b110, 16'h0010, 16'h0000, "lsl16");
    step(3'b011, 16'hA5C3, 16'hA5C3, "ld_a5c3");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      btnd = 1'b0;
      {btnl, btnc, btnr} = 3'($urandom_range(0, 7));
      sw = 16'($urandom);
      q.push_back(m_acc);
      @(posedge clk);
      #1 pop_chk("hold");
    end
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      b = (i % 3 == 0) ? 16'($urandom_range(0, 31)) : 16'($urandom);
      step(op, b, model(op, m_acc, b), "rand");
    end
    step(3'b011, 16'h00F0, model(3'b011, m_acc, 16'h00F0), "pre_rst");
    @(negedge clk);
    {btnl, btnc, btnr} = 3'b000;
    sw = 16'h0005;
    btnd = 1'b1;
    #2 btnu = 1'b1;
    #1 chk("rst_mid", led, 16'h0000);
    #1 btnu = 1'b0;
    q.push_back(16'h0005);
    @(posedge clk);
    #1 pop_chk("post_rst");
    @(negedge clk);
    btnd = 1'b0;
    m_acc = 16'h0005;
`ifdef CALC_BTND_EDGE_EN
    do_reset();
    @(negedge clk);
    {btnl, btnc, btnr} = 3'b000;
    sw = 16'h0001;
    btnd = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("edge_once", led, 16'h0001);
    @(negedge clk);
    btnd = 1'b0;
    @(negedge clk);
    btnd = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("edge_again", led, 16'h0002);
    @(negedge clk);
    btnd = 1'b0;
`endif
    chk("sb_empty", 16'(q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
